note_scheduler: RTL



---
 rtl/note_sched_pkg.sv | 19 +
 rtl/key_debounce.sv | 43 ++++
 rtl/note_scheduler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/note_sched_pkg.sv
// Shared types, widths and helpers for the note scheduler and its key front end.
package note_sched_pkg;
  localparam int NOTE_W = 4;
  localparam int OCT_W  = 3;
  localparam logic [NOTE_W-1:0] NOTE_SILENT = 4'd7;

  typedef enum logic [1:0] {IDLE, REQ, PLAY, STOP} state_t;

  // One load transfer towards the tone generator.
  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [OCT_W-1:0]  octave;
  } load_req_t;

  function automatic logic [OCT_W-1:0] clamp_octave(input logic [OCT_W-1:0] sel,
                                                    input logic [OCT_W-1:0] max_oct);
    return (sel > max_oct) ? max_oct : sel;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// One piano key: 2-flop synchroniser, stability counter, debounced level and
// single-cycle rise/fall pulses that coincide with the debounced level change.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_db,
  output logic rise,
  output logic fall
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync   <= '0;
      cnt    <= '0;
      key_db <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync <= {sync[0], key_in};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == key_db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Stable long enough: accept the new level.
        cnt    <= '0;
        key_db <= sync[1];
        rise   <= sync[1];
        fall   <= ~sync[1];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/note_scheduler.sv
// Arbitrates the piano keys onto the single tone generator and sequences its loads.
// Define SUSTAIN_EN to add the synchronised sustain pedal input.
module note_scheduler
  import note_sched_pkg::*;
#(
  parameter int NUM_KEYS        = 7,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MIN_HOLD_CYCLES = 5000000,
  parameter int MAX_OCTAVE      = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic [OCT_W-1:0]    octave_sel,
  input  logic                gen_ready,
`ifdef SUSTAIN_EN
  input  logic                sustain,
`endif
  output logic                note_load,
  output logic [NOTE_W-1:0]   note,
  output logic [OCT_W-1:0]    octave,
  output logic                note_valid,
  output logic [NUM_KEYS-1:0] cur_key
);
  localparam int HOLD_W = (MIN_HOLD_CYCLES > 0) ? $clog2(MIN_HOLD_CYCLES + 1) : 1;
  localparam logic [HOLD_W-1:0]   HOLD_MAX = HOLD_W'(MIN_HOLD_CYCLES);
  localparam logic [NUM_KEYS-1:0] KEY_ONE  = NUM_KEYS'(1);
  localparam logic [OCT_W-1:0]    OCT_MAX  = OCT_W'(MAX_OCTAVE);

  logic [NUM_KEYS-1:0] key_db, key_rise, key_fall;

  generate
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
        .clk    (clk),
        .rst    (rst),
        .key_in (key_in[i]),
        .key_db (key_db[i]),
        .rise   (key_rise[i]),
        .fall   (key_fall[i])
      );
    end
  endgenerate

  logic sustain_on;
`ifdef SUSTAIN_EN
  logic [1:0] sus_sync;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sus_sync <= '0;
    else     sus_sync <= {sus_sync[0], sustain};
  end
  assign sustain_on = sus_sync[1];
`else
  assign sustain_on = 1'b0;
`endif

  // Target: newest press wins (lowest index on ties); on release of the target
  // fall back to the lowest key still held. x & -x isolates the lowest set bit.
  logic [NUM_KEYS-1:0] tgt, tgt_n;
  logic [NOTE_W-1:0]   tgt_idx;

  always_comb begin
    tgt_n = tgt;
    if (|key_rise)
      tgt_n = key_rise & (~key_rise + KEY_ONE);
    else if (|(tgt & key_fall))
      tgt_n = key_db & (~key_db + KEY_ONE);
  end

  always_comb begin
    tgt_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (tgt[i]) tgt_idx = NOTE_W'(i);
  end

  state_t              state, state_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_n;
  load_req_t           req_q, req_n;
  logic [OCT_W-1:0]    sel_q, sel_n;
  logic [NUM_KEYS-1:0] key_q, key_n;
  logic [NUM_KEYS-1:0] cur_n;
  logic                valid_n, retarget, hold_done;

  assign hold_done = (hold_cnt == HOLD_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      req_q      <= '{note: NOTE_SILENT, octave: '0};
      sel_q      <= '0;
      key_q      <= '0;
      note_valid <= 1'b0;
      cur_key    <= '0;
      tgt        <= '0;
    end else begin
      state      <= state_n;
      hold_cnt   <= hold_n;
      req_q      <= req_n;
      sel_q      <= sel_n;
      key_q      <= key_n;
      note_valid <= valid_n;
      cur_key    <= cur_n;
      tgt        <= tgt_n;
    end
  end

  always_comb begin
    state_n  = state;
    hold_n   = hold_cnt;
    req_n    = req_q;
    sel_n    = sel_q;
    key_n    = key_q;
    valid_n  = note_valid;
    cur_n    = cur_key;
    retarget = 1'b0;
    case (state)
      IDLE: if (|tgt) retarget = 1'b1;
      // A request is never withdrawn: it completes even if its key vanished.
      REQ: if (gen_ready) begin
        state_n = PLAY;
        hold_n  = '0;
        valid_n = 1'b1;
        cur_n   = key_q;
      end
      PLAY: begin
        if (!hold_done) begin
          hold_n = hold_cnt + HOLD_W'(1);
        end else if (!(|tgt)) begin
          if (!sustain_on) begin
            state_n    = STOP;
            req_n.note = NOTE_SILENT;
          end
        end else if (tgt != cur_key || octave_sel != sel_q) begin
          retarget = 1'b1;
        end
      end
      STOP: if (gen_ready) begin
        state_n = IDLE;
        valid_n = 1'b0;
        cur_n   = '0;
      end
      default: state_n = IDLE;
    endcase
    if (retarget) begin
      state_n      = REQ;
      req_n.note   = tgt_idx;
      req_n.octave = clamp_octave(octave_sel, OCT_MAX);
      sel_n        = octave_sel;
      key_n        = tgt;
    end
  end

  assign note_load = (state == REQ) || (state == STOP);
  assign note      = req_q.note;
  assign octave    = req_q.octave;
endmodule
